// File: rtl/frame_update_scheduler_pkg.sv
// Shared constants for the per-frame game-logic update scheduler.
// Stage ordering matches the order the game logic must run in each frame.
package frame_update_scheduler_pkg;

  typedef enum int unsigned {
    STAGE_BALL    = 0,
    STAGE_PADDLE  = 1,
    STAGE_COLLIDE = 2,
    STAGE_BRICKS  = 3
  } game_stage_e;

  localparam int NUM_GAME_STAGES = int'(STAGE_BRICKS) + 1;
  localparam int OVERRUN_WIDTH   = 8;
  localparam logic [OVERRUN_WIDTH-1:0] OVERRUN_MAX = '1;

  // Stage index width; a single-stage build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Frame/stage handshake bundle between the video timing, the game-logic
// stages and the scheduler. The scheduler connects through the slave modport.
interface frame_update_scheduler_if
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_STAGES        = NUM_GAME_STAGES,
  parameter int FRAME_COUNT_WIDTH = 8
);
  logic                         frame_start;
  logic                         pause;
  logic                         clear_flags;
  logic [NUM_STAGES-1:0]        stage_done;
  logic [NUM_STAGES-1:0]        stage_start;
  logic                         busy;
  logic                         commit;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;
  logic [NUM_STAGES-1:0]        timeout_flags;
  logic [OVERRUN_WIDTH-1:0]     overrun_count;

  modport master (
    output frame_start, pause, clear_flags, stage_done,
    input  stage_start, busy, commit, frame_count, timeout_flags, overrun_count
  );

  modport slave (
    input  frame_start, pause, clear_flags, stage_done,
    output stage_start, busy, commit, frame_count, timeout_flags, overrun_count
  );
endinterface

// File: rtl/frame_update_scheduler_counter.sv
// Free-running up counter with synchronous clear; wraps at 2**WIDTH.
module frame_update_scheduler_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/frame_update_scheduler.sv
// Runs the game-logic stages in order once per video frame, then commits.
// Also tracks hung stages (sticky flags) and frame starts dropped while busy.
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_STAGES        = NUM_GAME_STAGES,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int TIMEOUT_WIDTH     = 10,
  parameter int FRAME_COUNT_WIDTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  frame_update_scheduler_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic                     done_seen_reg, done_seen_next;
  logic                     cur_done, advance, timeout_hit;
  logic [TIMEOUT_WIDTH-1:0] wait_count;
  logic [NUM_STAGES-1:0]    flag_set, flags_reg, flags_next;
  logic [OVERRUN_WIDTH-1:0] overrun_reg, overrun_next, overrun_base;
  logic                     overrun_inc;

  frame_update_scheduler_counter #(.WIDTH(TIMEOUT_WIDTH)) u_timeout (
    .clk    (clk),
    .reset  (reset || (state_reg == ST_START)),
    .enable (state_reg == ST_WAIT),
    .count  (wait_count)
  );

  frame_update_scheduler_counter #(.WIDTH(FRAME_COUNT_WIDTH)) u_frames (
    .clk    (clk),
    .reset  (reset),
    .enable (state_reg == ST_COMMIT),
    .count  (bus.frame_count)
  );

  // Only the active stage's done bit is ever looked at.
  assign cur_done = bus.stage_done[idx_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      done_seen_reg <= 1'b0;
      flags_reg     <= '0;
      overrun_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      done_seen_reg <= done_seen_next;
      flags_reg     <= flags_next;
      overrun_reg   <= overrun_next;
    end
  end

  // A done seen during START is held so WAIT advances on its first cycle.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    done_seen_next = done_seen_reg;
    advance        = 1'b0;
    timeout_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.frame_start && !bus.pause) begin
          state_next = ST_START;
          idx_next   = '0;
        end
      end
      ST_START: begin
        state_next     = ST_WAIT;
        done_seen_next = cur_done;
      end
      ST_WAIT: begin
        if (cur_done || done_seen_reg) begin
          advance = 1'b1;
        end else if (wait_count == TIMEOUT_MAX) begin
          advance     = 1'b1;
          timeout_hit = 1'b1;
        end
        if (advance) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_COMMIT;
          end else begin
            state_next = ST_START;
            idx_next   = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign bus.stage_start[gi] = (state_reg == ST_START) && (idx_reg == IDX_W'(gi));
    assign flag_set[gi]        = timeout_hit && (idx_reg == IDX_W'(gi));
  end

  // Clear applies first so a same-cycle set or increment survives it.
  always_comb begin
    overrun_inc  = bus.frame_start && !bus.pause && (state_reg != ST_IDLE);
    overrun_base = bus.clear_flags ? '0 : overrun_reg;
    overrun_next = overrun_base;
    if (overrun_inc && (overrun_base != OVERRUN_MAX)) begin
      overrun_next = overrun_base + OVERRUN_WIDTH'(1);
    end
    flags_next = (bus.clear_flags ? '0 : flags_reg) | flag_set;
  end

  assign bus.busy          = (state_reg != ST_IDLE);
  assign bus.commit        = (state_reg == ST_COMMIT);
  assign bus.timeout_flags = flags_reg;
  assign bus.overrun_count = overrun_reg;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench: per-frame timeline model computed from stage delays,
// with randomized done timing, overrun pulses, pause and flag clears.
module tb_frame_update_scheduler;
  import frame_update_scheduler_pkg::*;

  localparam int NS  = NUM_GAME_STAGES;
  localparam int T   = 16;
  localparam int TW  = 4;
  localparam int FCW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_update_scheduler_if #(.NUM_STAGES(NS), .FRAME_COUNT_WIDTH(FCW)) bus ();

  frame_update_scheduler #(
    .NUM_STAGES(NS), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(TW), .FRAME_COUNT_WIDTH(FCW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int fc_m     = 0;
  int ovr_m    = 0;
  logic [NS-1:0] flags_m = '0;

  int dly[NS];
  int ovr_pct   = 0;
  int pause_pct = 0;
  int clear_at  = -1;
  bit hold_all  = 1'b0;
  int ovr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_idle();
    bus.frame_start = 1'b0;
    bus.pause       = 1'b0;
    bus.clear_flags = 1'b0;
    bus.stage_done  = '0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_count"}, 32'(bus.frame_count), 32'(fc_m % 256));
    chk({tag, "_timeout_flags"}, 32'(bus.timeout_flags), 32'(flags_m));
    chk({tag, "_overrun"}, 32'(bus.overrun_count), 32'(ovr_m));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stage_start"}, 32'(bus.stage_start), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_commit"}, 32'(bus.commit), 32'd0);
    chk({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
    chk({tag, "_timeout_flags"}, 32'(bus.timeout_flags), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun_count), 32'd0);
  endtask

  // Stage i starts at s[i] (relative to FRAME_START at 0) and ends at a[i];
  // the next stage starts the cycle after, COMMIT follows the last stage.
  task automatic run_frame();
    int s[NS];
    int a[NS];
    bit to[NS];
    int cc, t, cur;
    bit pulse;
    logic [NS-1:0] exp_start;
    t = 1;
    for (int i = 0; i < NS; i++) begin
      s[i] = t;
      if (dly[i] <= T) begin
        a[i]  = s[i] + ((dly[i] < 1) ? 1 : dly[i]);
        to[i] = 1'b0;
      end else begin
        a[i]  = s[i] + T;
        to[i] = 1'b1;
      end
      t = a[i] + 1;
    end
    cc = t;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.frame_start = 1'b1;
    bus.pause       = 1'b0;
    bus.clear_flags = 1'b0;
    bus.stage_done  = hold_all ? '1 : '0;
    for (int c = 1; c <= cc + 1; c++) begin
      @(negedge clk);
      exp_start = '0;
      for (int i = 0; i < NS; i++) if (s[i] == c) exp_start[i] = 1'b1;
      chk("stage_start", 32'(bus.stage_start), 32'(exp_start));
      chk("commit", 32'(bus.commit), 32'(c == cc));
      chk("busy", 32'(bus.busy), 32'(c <= cc));
      if (c <= cc) begin
        cur = 0;
        for (int i = 0; i < NS; i++) if (s[i] <= c) cur = i;
        pulse = ($urandom_range(99) < ovr_pct);
        foreach (ovr_q[k]) if (ovr_q[k] == c) pulse = 1'b1;
        bus.frame_start = pulse;
        bus.pause       = ($urandom_range(99) < pause_pct);
        bus.clear_flags = (c == clear_at);
        if (hold_all) begin
          bus.stage_done = '1;
        end else begin
          bus.stage_done = '0;
          for (int j = 0; j < cur; j++) if ($urandom_range(1) == 1) bus.stage_done[j] = 1'b1;
          for (int i = 0; i < NS; i++) if (c == s[i] + dly[i]) bus.stage_done[i] = 1'b1;
        end
        if (bus.clear_flags) begin
          ovr_m   = 0;
          flags_m = '0;
        end
        if (pulse && !bus.pause && ovr_m < 255) ovr_m++;
        for (int i = 0; i < NS; i++) if (to[i] && c == a[i]) flags_m[i] = 1'b1;
      end else begin
        drive_idle();
      end
    end
    fc_m++;
    @(negedge clk);
    check_counts("frame");
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // In-order stages, done 3 cycles after each start.
    dly = '{3, 3, 3, 3};
    run_frame();

    // Done held high throughout: commit 9 cycles after frame start.
    dly = '{0, 0, 0, 0};
    hold_all = 1'b1;
    run_frame();
    hold_all = 1'b0;

    // Stage 2 hangs and is forced past by the timeout.
    dly = '{2, 2, 99, 1};
    run_frame();
    bus.clear_flags = 1'b1;
    @(negedge clk);
    bus.clear_flags = 1'b0;
    flags_m = '0;
    ovr_m   = 0;
    check_counts("clear");

    // Three dropped frame starts during one sequence.
    dly   = '{5, 5, 5, 5};
    ovr_q = '{3, 10, 15};
    run_frame();
    ovr_q.delete();

    // Clear colliding with an overrun and with a timeout in the same cycle.
    dly      = '{1, 1, 1, 99};
    clear_at = 23;
    ovr_q    = '{4, 23};
    run_frame();
    clear_at = -1;
    ovr_q.delete();

    // Paused: frame start ignored entirely.
    bus.pause       = 1'b1;
    bus.frame_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pause_busy", 32'(bus.busy), 32'd0);
      chk("pause_stage_start", 32'(bus.stage_start), 32'd0);
    end
    drive_idle();
    check_counts("pause");

    // Randomized frames.
    pause_pct = 50;
    repeat (40) begin
      foreach (dly[i]) dly[i] = $urandom_range(T + 4, 0);
      ovr_pct  = $urandom_range(30, 0);
      clear_at = $urandom_range(60, 1);
      run_frame();
    end
    pause_pct = 0;
    clear_at  = -1;

    // Overrun saturation: every busy cycle carries a frame start.
    dly     = '{99, 99, 99, 99};
    ovr_pct = 100;
    repeat (5) run_frame();
    ovr_pct = 0;

    // Reset while stage 1 is waiting.
    bus.frame_start = 1'b1;
    bus.stage_done  = '1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_stage1", 32'(bus.stage_start), 32'(4'b0010));
    @(negedge clk);
    reset = 1'b1;
    bus.stage_done = '0;
    @(negedge clk);
    check_all_zero("midreset");
    reset   = 1'b0;
    fc_m    = 0;
    ovr_m   = 0;
    flags_m = '0;
    dly = '{2, 1, 0, 3};
    run_frame();

    // Frame counter wrap after 256 commits.
    dly = '{0, 0, 0, 0};
    repeat (255) run_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
